// File: rtl/bcd_display_formatter.sv
// Binary to BCD display formatter.
// Converts an unsigned binary value into NUM_DIGITS packed BCD digits using
// sequential shift-and-add-3 (double dabble), one input bit per clock, MSB
// first. The decimal-point mask travels alongside the value. Results that do
// not fit in NUM_DIGITS digits are shown modulo 10^NUM_DIGITS with overflow set.
// data/pointEnable/overflow only change on the commit cycle, so a display can
// sample them continuously.
module bcd_display_formatter #(
    parameter int INPUT_WIDTH = 27,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic [INPUT_WIDTH-1:0]    value,
    input  logic [NUM_DIGITS-1:0]     pointIn,
    input  logic                      inValid,
    output logic                      inReady,
    output logic [NUM_DIGITS*4-1:0]   data,
    output logic [NUM_DIGITS-1:0]     pointEnable,
    output logic                      overflow,
    output logic                      done
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t                  state;
    logic [INPUT_WIDTH-1:0]  shiftReg;
    logic [BCD_W-1:0]        workBcd;
    logic [BCD_W-1:0]        adjustedBcd;
    logic [NUM_DIGITS-1:0]   workPoint;
    logic                    carryFlag;
    logic [CNT_W-1:0]        bitCount;

    // Add-3 correction: any digit that would reach 10 or more after the
    // coming doubling is pre-biased so the shift carries into the next digit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : gen_adjust
            assign adjustedBcd[gi*4 +: 4] = (workBcd[gi*4 +: 4] >= 4'd5)
                                          ? workBcd[gi*4 +: 4] + 4'd3
                                          : workBcd[gi*4 +: 4];
        end
    endgenerate

    // The block can only take a new value while nothing is in flight.
    assign inReady = (state == IDLE);

    // Conversion sequencer: capture, shift INPUT_WIDTH times, then publish.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            shiftReg    <= '0;
            workBcd     <= '0;
            workPoint   <= '0;
            carryFlag   <= 1'b0;
            bitCount    <= '0;
            data        <= '0;
            pointEnable <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (inValid) begin
                        shiftReg  <= value;
                        workPoint <= pointIn;
                        workBcd   <= '0;
                        carryFlag <= 1'b0;
                        bitCount  <= CNT_W'(INPUT_WIDTH);
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Bit leaving the top digit means the value exceeds the
                    // display; remember it but keep the low digits exact.
                    workBcd   <= {adjustedBcd[BCD_W-2:0], shiftReg[INPUT_WIDTH-1]};
                    shiftReg  <= shiftReg << 1;
                    carryFlag <= carryFlag | adjustedBcd[BCD_W-1];
                    bitCount  <= bitCount - 1'b1;
                    if (bitCount == CNT_W'(1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    data        <= workBcd;
                    pointEnable <= workPoint;
                    overflow    <= carryFlag;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Bench for bcd_display_formatter: two instances (27-bit/8-digit and
// 8-bit/2-digit) checked every cycle against an arithmetic model, plus
// directed vectors with literal expected results.
`timescale 1ns/1ps
module tb_bcd_display_formatter;

    logic        clock  = 1'b0;
    logic        resetN = 1'b0;

    // Instance A: INPUT_WIDTH=27, NUM_DIGITS=8
    logic        validA = 1'b0;
    logic [26:0] valueA = '0;
    logic [7:0]  ptA    = '0;
    logic        readyA;
    logic [31:0] dataA;
    logic [7:0]  peA;
    logic        ovfA;
    logic        doneA;

    // Instance B: INPUT_WIDTH=8, NUM_DIGITS=2
    logic        validB = 1'b0;
    logic [7:0]  valueB = '0;
    logic [1:0]  ptB    = '0;
    logic        readyB;
    logic [7:0]  dataB;
    logic [1:0]  peB;
    logic        ovfB;
    logic        doneB;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bcd_display_formatter #(.INPUT_WIDTH(27), .NUM_DIGITS(8)) dutA (
        .clock(clock), .resetN(resetN), .value(valueA), .pointIn(ptA),
        .inValid(validA), .inReady(readyA), .data(dataA),
        .pointEnable(peA), .overflow(ovfA), .done(doneA)
    );

    bcd_display_formatter #(.INPUT_WIDTH(8), .NUM_DIGITS(2)) dutB (
        .clock(clock), .resetN(resetN), .value(valueB), .pointIn(ptB),
        .inValid(validB), .inReady(readyB), .data(dataB),
        .pointEnable(peB), .overflow(ovfB), .done(doneB)
    );

    // ---------------- instance accessors ----------------
    function automatic int widthOf(int i);
        return (i == 0) ? 27 : 8;
    endfunction
    function automatic int digitsOf(int i);
        return (i == 0) ? 8 : 2;
    endfunction
    function automatic logic getValid(int i);
        return (i == 0) ? validA : validB;
    endfunction
    function automatic longint unsigned getValue(int i);
        return (i == 0) ? longint'(valueA) : longint'(valueB);
    endfunction
    function automatic logic [7:0] getPt(int i);
        return (i == 0) ? ptA : {6'd0, ptB};
    endfunction
    function automatic logic getReady(int i);
        return (i == 0) ? readyA : readyB;
    endfunction
    function automatic logic [31:0] getData(int i);
        return (i == 0) ? dataA : {24'd0, dataB};
    endfunction
    function automatic logic [7:0] getPe(int i);
        return (i == 0) ? peA : {6'd0, peB};
    endfunction
    function automatic logic getOvf(int i);
        return (i == 0) ? ovfA : ovfB;
    endfunction
    function automatic logic getDone(int i);
        return (i == 0) ? doneA : doneB;
    endfunction

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] toBcd(longint unsigned v, int n);
        logic [31:0]     r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < n; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(int n);
        longint unsigned p;
        p = 1;
        for (int d = 0; d < n; d++) p = p * 10;
        return p;
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A request seen while idle completes INPUT_WIDTH+1 edges later with the
    // decimal value of the captured number; nothing else moves the outputs.
    logic            mBusy   [2] = '{1'b0, 1'b0};
    int              mLeft   [2] = '{0, 0};
    longint unsigned mVal    [2] = '{0, 0};
    logic [7:0]      mPt     [2] = '{8'd0, 8'd0};
    logic [31:0]     expData [2] = '{32'd0, 32'd0};
    logic [7:0]      expPt   [2] = '{8'd0, 8'd0};
    logic            expOvf  [2] = '{1'b0, 1'b0};
    logic            expDone [2] = '{1'b0, 1'b0};

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                mBusy[i]   <= 1'b0;
                mLeft[i]   <= 0;
                expData[i] <= '0;
                expPt[i]   <= '0;
                expOvf[i]  <= 1'b0;
                expDone[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                expDone[i] <= 1'b0;
                if (mBusy[i]) begin
                    mLeft[i] <= mLeft[i] - 1;
                    if (mLeft[i] == 1) begin
                        mBusy[i]   <= 1'b0;
                        expData[i] <= toBcd(mVal[i], digitsOf(i));
                        expPt[i]   <= mPt[i];
                        expOvf[i]  <= (mVal[i] >= pow10(digitsOf(i)));
                        expDone[i] <= 1'b1;
                    end
                end else if (getValid(i)) begin
                    mBusy[i] <= 1'b1;
                    mLeft[i] <= widthOf(i) + 1;
                    mVal[i]  <= getValue(i);
                    mPt[i]   <= getPt(i);
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            chk("inReady", i, 32'(getReady(i)), 32'(!mBusy[i]));
            chk("done", i, 32'(getDone(i)), 32'(expDone[i]));
            chk("data", i, getData(i), expData[i]);
            chk("pointEnable", i, 32'(getPe(i)), 32'(expPt[i]));
            chk("overflow", i, 32'(getOvf(i)), 32'(expOvf[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setIn(int i, logic v, longint unsigned val, logic [7:0] pt);
        if (i == 0) begin
            validA = v; valueA = 27'(val); ptA = pt;
        end else begin
            validB = v; valueB = 8'(val); ptB = pt[1:0];
        end
    endtask

    task automatic accept(int i, longint unsigned val, logic [7:0] pt);
        int n;
        n = 0;
        while (!getReady(i) && n < 100) begin
            tick();
            n++;
        end
        if (!getReady(i)) chk("ready_timeout", i, 32'(getReady(i)), 32'd1);
        setIn(i, 1'b1, val, pt);
        tick();
    endtask

    task automatic waitDone(int i, int lat, logic [31:0] litData, logic litOvf, logic [7:0] litPt);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!getDone(i) && n < 100);
        chk("latency", i, 32'(n), 32'(lat));
        chk("data_lit", i, getData(i), litData);
        chk("ovf_lit", i, 32'(getOvf(i)), 32'(litOvf));
        chk("pe_lit", i, 32'(getPe(i)), 32'(litPt));
        $display("inst=%0d data=%h pointEnable=%h overflow=%0b latency=%0d", i, getData(i), getPe(i), getOvf(i), n);
    endtask

    task automatic runVec(int i, longint unsigned val, logic [7:0] pt, logic [31:0] litData, logic litOvf);
        accept(i, val, pt);
        setIn(i, 1'b0, 0, 8'd0);
        waitDone(i, widthOf(i) + 1, litData, litOvf, (i == 0) ? pt : {6'd0, pt[1:0]});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        longint unsigned v;
        logic [7:0]      p;

        // Pin the model arithmetic to hand-computed values.
        chk("model_bcd", 0, toBcd(12345678, 8), 32'h12345678);
        chk("model_bcd", 0, toBcd(134217727, 8), 32'h34217727);
        chk("model_bcd", 1, toBcd(255, 2), 32'h00000055);

        resetN = 1'b0;
        repeat (3) tick();
        chk("reset_data", 0, dataA, 32'd0);
        chk("reset_ready", 0, 32'(readyA), 32'd1);
        resetN = 1'b1;

        // Instance A directed vectors (first one on the first edge after reset)
        runVec(0, 0,         8'h00, 32'h00000000, 1'b0);
        runVec(0, 12345678,  8'h04, 32'h12345678, 1'b0);
        runVec(0, 134217727, 8'h81, 32'h34217727, 1'b1);
        runVec(0, 100000000, 8'hFF, 32'h00000000, 1'b1);
        runVec(0, 99999999,  8'h10, 32'h99999999, 1'b0);

        // Held inValid during conversion is ignored, then accepted back-to-back.
        accept(0, 99999999, 8'h00);
        setIn(0, 1'b1, 5, 8'h02);
        waitDone(0, 28, 32'h99999999, 1'b0, 8'h00);
        waitDone(0, 29, 32'h00000005, 1'b0, 8'h02);
        setIn(0, 1'b0, 0, 8'h00);

        // Reset mid-conversion abandons the job and clears outputs at once.
        accept(0, 42, 8'h01);
        setIn(0, 1'b0, 0, 8'h00);
        repeat (9) tick();
        resetN = 1'b0;
        #1;
        chk("midreset_data", 0, dataA, 32'd0);
        chk("midreset_pe", 0, 32'(peA), 32'd0);
        chk("midreset_ready", 0, 32'(readyA), 32'd1);
        chk("midreset_done", 0, 32'(doneA), 32'd0);
        repeat (2) tick();
        resetN = 1'b1;
        for (int c = 0; c < 35; c++) begin
            tick();
            chk("no_done_after_reset", 0, 32'(doneA), 32'd0);
        end

        // Instance B directed vectors
        runVec(1, 255, 8'h02, 32'h00000055, 1'b1);
        runVec(1, 99,  8'h00, 32'h00000099, 1'b0);
        runVec(1, 100, 8'h01, 32'h00000000, 1'b1);
        runVec(1, 7,   8'h03, 32'h00000007, 1'b0);

        // Random values, expectations from the model arithmetic
        for (int r = 0; r < 12; r++) begin
            v = longint'($urandom & 32'h07FF_FFFF);
            p = 8'($urandom);
            runVec(0, v, p, toBcd(v, 8), (v >= 64'd100000000));
        end
        for (int r = 0; r < 12; r++) begin
            v = longint'($urandom_range(0, 255));
            p = {6'd0, 2'($urandom)};
            runVec(1, v, p, toBcd(v, 2), (v >= 64'd100));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_display_formatter.md
BCD_DISPLAY_FORMATTER -- requirements
Module: bcd_display_formatter

Interface
REQ-001 Parameter INPUT_WIDTH, default 27; binary input width, 1..32.
REQ-002 Parameter NUM_DIGITS, default 8; decimal digits produced, 4 bits each.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port resetN  input  1  asynchronous, active-low reset.
REQ-005 Port value  input  INPUT_WIDTH  unsigned binary number to convert.
REQ-006 Port pointIn  input  NUM_DIGITS  decimal-point mask to display with value.
REQ-007 Port inValid  input  1  value/pointIn offered this cycle.
REQ-008 Port inReady  output  1  block can accept a new value.
REQ-009 Port data  output  NUM_DIGITS*4  BCD result; digit i in bits [4i+3:4i], digit 0 least significant.
REQ-010 Port pointEnable  output  NUM_DIGITS  decimal-point mask paired with data.
REQ-011 Port overflow  output  1  displayed result truncated (value >= 10^NUM_DIGITS).
REQ-012 Port done  output  1  one-cycle pulse: data/pointEnable/overflow just updated.

Function
REQ-013 Shall implement sequential shift-and-add-3 (double dabble), one input bit per clock, MSB first.
REQ-014 States: IDLE, CONVERT, COMMIT.
REQ-015 inReady shall be 1 exactly when state is IDLE.
REQ-016 IDLE: edge with inValid=1 shall capture value and pointIn into working registers, clear working BCD register and carry flag, load bit counter with INPUT_WIDTH, go to CONVERT.
REQ-017 CONVERT, each edge: every working nibble >= 5 gets +3, then BCD||shift register shifts left 1, counter decrements; after the INPUT_WIDTH-th shift go to COMMIT.
REQ-018 Bit shifted out of the top nibble shall OR into a sticky carry flag.
REQ-019 COMMIT edge: data <= working BCD, pointEnable <= captured mask, overflow <= carry flag, done pulses 1, return to IDLE.
REQ-020 Latency: acceptance at edge k -> outputs updated and done=1 after edge k+INPUT_WIDTH+1; inReady high again same edge.
REQ-021 On overflow, data shall hold value mod 10^NUM_DIGITS in BCD.
REQ-022 data, pointEnable, overflow shall stay constant between COMMIT edges (downstream display samples continuously).
REQ-023 inValid outside IDLE shall be ignored; no queuing.
REQ-024 Each data nibble shall always be 0..9.
REQ-025 done shall be 0 on every cycle except the one after a COMMIT edge.

Reset
REQ-026 resetN=0 shall immediately force state IDLE, data=0, pointEnable=0, overflow=0, done=0, inReady=1, working registers cleared.
REQ-027 Reset mid-conversion shall abandon it; no done pulse, outputs keep reset values until the next full conversion.
REQ-028 First acceptance allowed on the first rising edge after resetN deasserts.

Verification
REQ-029 value=0, pointIn=0 -> after 28 edges data=0x00000000, overflow=0, one done pulse.
REQ-030 value=12345678, pointIn=0x04 -> done after edge k+28; data=0x12345678, pointEnable=0x04, overflow=0; data unchanged during conversion.
REQ-031 value=134217727 (2^27-1) -> data=0x34217727, overflow=1.
REQ-032 Accept 99999999, then hold inValid=1 with value=5 throughout conversion -> 5 ignored until inReady=1; first result 0x99999999, second 0x00000005 back-to-back.
REQ-033 Accept 42, assert resetN=0 at cycle 10 -> outputs 0 immediately, inReady=1, no done pulse.
REQ-034 Random values vs reference model, INPUT_WIDTH=27 and INPUT_WIDTH=8 with NUM_DIGITS=2 (value 255 -> 0x55, overflow=1).
